min_sad_select: RTL

MIN_SAD_SELECT -- requirements
Module: min_sad_select

---
 rtl/fsbm_pkg.sv | 20 ++
 rtl/mv_scan_counter.sv | 75 +++++++
 rtl/min_sad_select.sv | 113 +++++++++++
 3 files changed

// File: rtl/fsbm_pkg.sv
// Shared definitions for the full-search block-matching datapath.
// Holds default SAD / motion-vector widths, the controller state encoding and a
// helper returning the number of candidates in a +/-SR search window.
package fsbm_pkg;

    localparam int unsigned SadWDefault = 12;
    localparam int unsigned MvWDefault  = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    // Number of (dx, dy) candidates for a search range of +/-sr.
    function automatic int unsigned num_candidates(input int unsigned sr);
        return (2 * sr + 1) * (2 * sr + 1);
    endfunction

endpackage

// File: rtl/mv_scan_counter.sv
// Raster-order offset counter for the motion search.
// dx runs -SR..+SR, then wraps to -SR while dy advances. Flags the final
// candidate (dx = dy = +SR) so the controller can close the search.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   clear - load dx = dy = -SR and clear the candidate count
//   step  - advance to the next candidate (one accepted SAD)
//   dx    - current horizontal offset (signed)
//   dy    - current vertical offset (signed)
//   last  - current candidate is the final one of the window
module mv_scan_counter
    import fsbm_pkg::*;
#(
    parameter int unsigned SR   = 7,
    parameter int unsigned MV_W = MvWDefault
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   step,
    output logic signed [MV_W-1:0] dx,
    output logic signed [MV_W-1:0] dy,
    output logic                   last
);

    localparam int unsigned NumCand = num_candidates(SR);
    localparam int unsigned CntW    = $clog2(NumCand + 1);

    localparam logic signed [MV_W-1:0] PosLim = MV_W'(SR);
    localparam logic signed [MV_W-1:0] NegLim = -PosLim;

    logic [CntW-1:0]        count_q, count_d;
    logic signed [MV_W-1:0] dx_q, dx_d;
    logic signed [MV_W-1:0] dy_q, dy_d;

    assign last = (count_q == CntW'(NumCand - 1));

    always_comb begin
        count_d = count_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        if (clear) begin
            count_d = '0;
            dx_d    = NegLim;
            dy_d    = NegLim;
        end else if (step && !last) begin
            // Stepping past the final candidate holds the offsets at +SR/+SR.
            count_d = count_q + CntW'(1);
            if (dx_q == PosLim) begin
                dx_d = NegLim;
                dy_d = dy_q + MV_W'(1);
            end else begin
                dx_d = dx_q + MV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
        end else begin
            count_q <= count_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
        end
    end

    assign dx = dx_q;
    assign dy = dy_q;

endmodule

// File: rtl/min_sad_select.sv
// Minimum-SAD selector for full-search motion estimation.
// Accepts (2*SR+1)^2 candidate SADs in raster order, keeps the smallest
// (earliest wins on ties) together with its offset, and presents the result
// with a valid/ready handshake.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   start     - pulse in IDLE to begin a new search window
//   sad_valid - sad carries a candidate
//   sad       - candidate SAD
//   sad_ready - candidate accepted this cycle (SCAN only)
//   res_valid - result held and valid (DONE)
//   res_ready - consumer takes the result
//   best_sad  - minimum SAD found
//   mv_x/mv_y - signed offset of the minimum
//   busy      - search in progress or result pending
module min_sad_select
    import fsbm_pkg::*;
#(
    parameter int unsigned SR    = 7,
    parameter int unsigned SAD_W = SadWDefault,
    parameter int unsigned MV_W  = MvWDefault
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sad_valid,
    input  logic [SAD_W-1:0]       sad,
    output logic                   sad_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SAD_W-1:0]       best_sad,
    output logic signed [MV_W-1:0] mv_x,
    output logic signed [MV_W-1:0] mv_y,
    output logic                   busy
);

    state_e state_q, state_d;

    logic                   first_q;
    logic [SAD_W-1:0]       best_sad_q;
    logic signed [MV_W-1:0] mv_x_q, mv_y_q;
    logic                   res_valid_q, busy_q;

    logic                   load;
    logic                   accept;
    logic                   take;
    logic                   last;
    logic signed [MV_W-1:0] dx, dy;

    assign sad_ready = (state_q == StScan);
    assign accept    = sad_valid & sad_ready;
    assign load      = (state_q == StIdle) & start;
    // Strict unsigned compare keeps the earliest candidate on ties.
    assign take      = accept & (first_q | (sad < best_sad_q));

    mv_scan_counter #(
        .SR   (SR),
        .MV_W (MV_W)
    ) u_scan_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (load),
        .step  (accept),
        .dx    (dx),
        .dy    (dy),
        .last  (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StScan;
            StScan: if (accept && last) state_d = StDone;
            StDone: if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            first_q     <= 1'b0;
            best_sad_q  <= '1;
            mv_x_q      <= '0;
            mv_y_q      <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= (state_d == StDone);
            busy_q      <= (state_d != StIdle);
            if (load) begin
                first_q <= 1'b1;
            end else if (accept) begin
                first_q <= 1'b0;
            end
            if (take) begin
                best_sad_q <= sad;
                mv_x_q     <= dx;
                mv_y_q     <= dy;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign best_sad  = best_sad_q;
    assign mv_x      = mv_x_q;
    assign mv_y      = mv_y_q;

endmodule
